// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, word byte count and CR/LF constants.
// APPEND_CRLF_EN appends CR, LF after the four word bytes.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
`ifdef APPEND_CRLF_EN
  localparam int BYTES_PER_WORD = 6;
`else
  localparam int BYTES_PER_WORD = 4;
`endif
  localparam int IDX_W = 3;
  // Byte i of the transmit sequence: word bytes MSB first, then CR, LF
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [IDX_W-1:0] i);
    logic [31:0] s;
    s = w << {i[1:0], 3'b000};
    return (i == 3'd4) ? CR : (i == 3'd5) ? LF : s[31:24];
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte as start bit, 8 data bits LSB first, stop bit;
// accepts the next byte in the last stop cycle so consecutive bytes have no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       idle,
  output logic       tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    nxt = state;
    byte_ready = 1'b0;
    unique case (state)
      IDLE: begin
        byte_ready = 1'b1;
        nxt = byte_valid ? START : IDLE;
      end
      START: nxt = last ? DATA : START;
      DATA: nxt = (last && bit_idx == 3'd7) ? STOP : DATA;
      STOP: begin
        byte_ready = last;
        nxt = last ? (byte_valid ? START : IDLE) : STOP;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      if (state == DATA && last) bit_idx <= bit_idx + 1'b1;
      sh <= (byte_valid && byte_ready) ? byte_data : (state == DATA && last) ? sh >> 1 : sh;
    end
  end
  assign idle = state == IDLE;
  assign tx = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : 1'b1;
endmodule

// File: rtl/word_uart_tx.sv
// word_uart_tx: sends a 32-bit word as four UART bytes, MSB byte first.
// Define APPEND_CRLF_EN to follow each word with CR, LF.
module word_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        word_valid,
  input  logic [31:0] word,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("word_uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  logic [31:0] snap;
  logic [IDX_W-1:0] idx;
  logic hs, byte_valid, byte_ready, idle;
  logic [7:0] byte_data;
  assign word_ready = idle;
  assign busy = !idle;
  assign hs = word_valid && idle;
  // idx is the next byte to hand over; 0 means nothing left of this word
  assign byte_valid = hs || idx != '0;
  assign byte_data = hs ? word[31:24] : pick_byte(snap, idx);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap <= '0;
      idx <= '0;
    end else if (hs) begin
      snap <= word;
      idx <= IDX_W'(1);
    end else if (byte_valid && byte_ready) begin
      idx <= (idx == IDX_W'(BYTES_PER_WORD - 1)) ? '0 : idx + 1'b1;
    end
  end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .idle(idle),
    .tx(tx)
  );
endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: directed bench for word_uart_tx at 10 clocks per bit.
module tb_word_uart_tx;
`ifdef APPEND_CRLF_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif
  localparam int FL = NB * 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic word_valid = 1'b0;
  logic [31:0] word = '0;
  logic word_ready, tx, busy;
  int total = 0;
  int bad = 0;
  logic cap [0:2047];
  logic rdy [0:2047];
  word_uart_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .word_valid(word_valid),
    .word(word),
    .word_ready(word_ready),
    .tx(tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] eb(input logic [31:0] w, input int b);
    case (b)
      0: return w[31:24];
      1: return w[23:16];
      2: return w[15:8];
      3: return w[7:0];
      4: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction
  function automatic logic exp_tx(input logic [31:0] w, input int k);
    logic [7:0] v;
    int bt;
    if (k >= FL) return 1'b1;
    bt = (k % 100) / 10;
    if (bt == 0) return 1'b0;
    if (bt == 9) return 1'b1;
    v = eb(w, k / 100);
    return v[bt-1];
  endfunction
  task automatic start(input logic [31:0] w, input bit hold);
    word = w;
    word_valid = 1'b1;
    @(negedge clk);
    if (!hold) word_valid = 1'b0;
  endtask
  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) word_valid = 1'b0;
      cap[i] = tx;
      rdy[i] = word_ready;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    word_valid = 1'b1;
    word = 32'h70617373;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", word_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    word_valid = 1'b0;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_discard_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_discard_busy got=%b want=0", busy); end
  endtask
  task automatic test_pass;
    int errs;
    logic [7:0] d;
    start(32'h70617373, 1'b0);
    capture(FL + 1, -1);
    total++; if (cap[0] !== 1'b0) begin bad++; $display("FAIL pass_first_low got=%b want=0", cap[0]); end
    errs = 0;
    for (int k = 0; k < FL; k++) if (cap[k] !== exp_tx(32'h70617373, k)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL pass_wave errs=%0d want=0", errs); end
    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < 8; j++) d[j] = cap[b*100 + 15 + 10*j];
      total++; if (d !== eb(32'h70617373, b)) begin bad++; $display("FAIL pass_byte%0d got=%h want=%h", b, d, eb(32'h70617373, b)); end
    end
    errs = 0;
    for (int k = 0; k < FL; k++) if (rdy[k] !== 1'b0) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL pass_ready_low errs=%0d want=0", errs); end
    total++; if (rdy[FL] !== 1'b1) begin bad++; $display("FAIL pass_ready_end got=%b want=1", rdy[FL]); end
  endtask
  task automatic test_hold;
    int errs;
    start(32'h70617373, 1'b1);
    word = 32'h6661696C;
    capture(2*FL + 2, FL + 1);
    errs = 0;
    for (int k = 0; k < FL; k++) if (cap[k] !== exp_tx(32'h70617373, k)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL hold_snapshot errs=%0d want=0", errs); end
    total++; if (cap[FL] !== 1'b1 || rdy[FL] !== 1'b1) begin bad++; $display("FAIL hold_gap tx=%b ready=%b want=1,1", cap[FL], rdy[FL]); end
    total++; if (cap[FL+1] !== 1'b0) begin bad++; $display("FAIL hold_second_start got=%b want=0", cap[FL+1]); end
    errs = 0;
    for (int k = 0; k < FL; k++) if (cap[FL+1+k] !== exp_tx(32'h6661696C, k)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL hold_fail_wave errs=%0d want=0", errs); end
    total++; if (rdy[2*FL+1] !== 1'b1 || cap[2*FL+1] !== 1'b1) begin bad++; $display("FAIL hold_idle_end ready=%b tx=%b want=1,1", rdy[2*FL+1], cap[2*FL+1]); end
  endtask
  task automatic test_zero;
    int errs, lows;
    start(32'h00000000, 1'b0);
    capture(FL + 1, -1);
    errs = 0;
    for (int k = 0; k < FL; k++) if (cap[k] !== exp_tx(32'h0, k)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL zero_wave errs=%0d want=0", errs); end
    for (int b = 0; b < 4; b++) begin
      lows = 0;
      for (int k = 0; k < 100; k++) if (cap[b*100 + k] === 1'b0) lows++;
      total++; if (lows !== 90 || cap[b*100 + 90] !== 1'b1) begin bad++; $display("FAIL zero_byte%0d lows=%0d stop=%b want=90,1", b, lows, cap[b*100 + 90]); end
    end
  endtask
  task automatic test_reset_mid;
    int lows;
    start(32'h70617373, 1'b0);
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (word_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", word_ready); end
    lows = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL midrst_quiet lows=%0d want=0", lows); end
  endtask
`ifdef APPEND_CRLF_EN
  task automatic test_crlf;
    logic [7:0] d;
    start(32'h30303830, 1'b0);
    capture(FL + 1, -1);
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++) d[j] = cap[b*100 + 15 + 10*j];
      total++; if (d !== eb(32'h30303830, b)) begin bad++; $display("FAIL crlf_byte%0d got=%h want=%h", b, d, eb(32'h30303830, b)); end
    end
    total++; if (rdy[599] !== 1'b0 || rdy[600] !== 1'b1) begin bad++; $display("FAIL crlf_ready r599=%b r600=%b want=0,1", rdy[599], rdy[600]); end
  endtask
`endif
  initial begin
    test_reset;
    test_pass;
    test_hold;
    test_zero;
    test_reset_mid;
`ifdef APPEND_CRLF_EN
    test_crlf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/word_uart_tx.md
WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 word_valid  input  1  word offered for transmission.
REQ-006 word  input  32  four ASCII bytes (e.g. core status word "pass"/"fail"/hex PC); byte 3 = word[31:24] is sent first.
REQ-007 word_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  UART serial line, idle high.
REQ-009 busy  output  1  a frame sequence is in progress.

Function
REQ-010 CLKS_PER_BIT SHALL be CLK_HZ/BAUD (integer truncation); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-011 Handshake SHALL be word_valid && word_ready on a posedge; word SHALL be snapshotted into an internal register at that edge and later changes to word SHALL be ignored.
REQ-012 word_ready SHALL be 1 only in IDLE; busy SHALL be its complement.
REQ-013 The state machine SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on handshake; tx SHALL go low on the first cycle after the handshake edge.
REQ-015 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-016 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles, then -> STOP.
REQ-017 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles; then -> START with next byte if bytes remain, else -> IDLE.
REQ-018 Byte order SHALL be word[31:24], [23:16], [15:8], [7:0]; no idle gap between bytes.
REQ-019 One word SHALL occupy exactly 40*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle; word_ready SHALL reassert on the following cycle.
REQ-020 word_valid asserted while busy SHALL be ignored, not queued.
REQ-021 Back-to-back words: a handshake in the first IDLE cycle SHALL start the next frame with exactly one idle-high cycle between stop and start bits.
REQ-022 Bit-period counter and byte index SHALL wrap to 0 at each bit/byte boundary; no counter may overflow its declared width.

Reset
REQ-023 rst_n=0 at a posedge SHALL force state=IDLE, tx=1, word_ready=1, busy=0, counters and snapshot register to 0, on the next cycle, including mid-frame.
REQ-024 A handshake coincident with rst_n=0 SHALL be discarded.

Configuration
REQ-025 Macro APPEND_CRLF_EN: when defined, two extra bytes 0x0D then 0x0A SHALL follow the four word bytes (60*CLKS_PER_BIT cycles per word); when undefined, exactly four bytes SHALL be sent.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, bytes-per-word constant, and CR/LF constants.
REQ-027 Per-byte serialisation (START/DATA/STOP timing, tx driver) SHALL be sub-module uart_byte_tx with byte_valid/byte_ready handshake; word_uart_tx sequences bytes into it.

Verification (CLK_HZ=1000, BAUD=100, CLKS_PER_BIT=10)
REQ-028 Reset, then word=0x70617373 ("pass") valid one cycle -> tx low next cycle; decoded bytes 0x70,0x61,0x73,0x73; word_ready high after 400 cycles.
REQ-029 Change word to 0x6661696C after handshake, hold word_valid high -> transmitted bytes still "pass"; second frame "fail" starts after one idle cycle.
REQ-030 rst_n low for one cycle at cycle 150 of a frame -> tx=1, busy=0 next cycle; no further edges on tx.
REQ-031 word=0x00000000 -> each byte is 1 start, 8 zero bits, 1 stop (tx low 90 cycles, high 10, repeated 4 times).
REQ-032 With APPEND_CRLF_EN, word=0x30303830 -> bytes "0080",0x0D,0x0A; word_ready after 600 cycles.
